// File: rtl/cache_ctrl.sv
// Cache management unit between the CPU memory stage and a 2-way set-associative cache array.
// Optional hit/miss statistics counters are enabled by defining CACHE_STAT_EN.
module cache_ctrl #(
    parameter int unsigned ADDR_BITS  = 32,
    parameter int unsigned TAG_BITS   = 23,
    parameter int unsigned INDEX_BITS = 5,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_BITS-1:0] addr_rw,
    input  logic                 en_r,
    input  logic                 en_w,
    input  logic [2:0]           u_b_h_w,
    input  logic [31:0]          data_w,
    output logic [31:0]          data_r,
    output logic                 stall,
    output logic [ADDR_BITS-1:0] cache_addr,
    output logic                 cache_load,
    output logic                 cache_edit,
    output logic                 cache_store,
    output logic [2:0]           cache_u_b_h_w,
    output logic [31:0]          cache_din,
    input  logic                 cache_hit,
    input  logic [31:0]          cache_dout,
    input  logic                 cache_valid,
    input  logic                 cache_dirty,
    input  logic [TAG_BITS-1:0]  cache_tag,
    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [31:0]          mem_din,
    input  logic [31:0]          mem_dout,
    input  logic                 mem_ack
`ifdef CACHE_STAT_EN
    ,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
`endif
);

    localparam int unsigned WC_BITS = $clog2(LINE_WORDS);
    localparam int unsigned IDX_LSB = WC_BITS + 2;
    localparam int unsigned TAG_LSB = IDX_LSB + INDEX_BITS;
    localparam logic [2:0]  UBHW_WORD = 3'b010;

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_BACK, S_FILL, S_RETRY} state_t;

    state_t                 state_q, state_d;
    logic [WC_BITS-1:0]     word_cnt_q, word_cnt_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [TAG_BITS-1:0]    victim_tag_q, victim_tag_d;
    logic [ADDR_BITS-1:0]   req_addr_q, req_addr_d;
    logic [2:0]             req_ubhw_q, req_ubhw_d;
    logic [31:0]            req_data_q, req_data_d;
    logic                   req_ld_q, req_ld_d;
    logic                   req_st_q, req_st_d;
    logic [31:0]            data_r_q, data_r_d;
    logic                   mem_cs_q, mem_cs_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [31:0]            mem_din_q, mem_din_d;
`ifdef CACHE_STAT_EN
    logic [31:0]            hit_cnt_q, hit_cnt_d;
    logic [31:0]            miss_cnt_q, miss_cnt_d;
    logic                   first_q, first_d;
`endif

    logic [ADDR_BITS-1:0]   line_addr;
    logic [ADDR_BITS-1:0]   victim_addr;

    assign line_addr   = {req_addr_q[ADDR_BITS-1:IDX_LSB], word_cnt_q, 2'b00};
    assign victim_addr = {victim_tag_q, req_addr_q[TAG_LSB-1:IDX_LSB], word_cnt_q, 2'b00};

    assign data_r   = data_r_q;
    assign mem_cs   = mem_cs_q;
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
`ifdef CACHE_STAT_EN
    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            word_cnt_q   <= '0;
            rd_vld_q     <= 1'b0;
            victim_tag_q <= '0;
            req_addr_q   <= '0;
            req_ubhw_q   <= '0;
            req_data_q   <= '0;
            req_ld_q     <= 1'b0;
            req_st_q     <= 1'b0;
            data_r_q     <= '0;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
`ifdef CACHE_STAT_EN
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            first_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            rd_vld_q     <= rd_vld_d;
            victim_tag_q <= victim_tag_d;
            req_addr_q   <= req_addr_d;
            req_ubhw_q   <= req_ubhw_d;
            req_data_q   <= req_data_d;
            req_ld_q     <= req_ld_d;
            req_st_q     <= req_st_d;
            data_r_q     <= data_r_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
`ifdef CACHE_STAT_EN
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            first_q      <= first_d;
`endif
        end
    end

    // Cache-array controls are combinational because the array itself registers the lookup.
    always_comb begin
        state_d       = state_q;
        word_cnt_d    = word_cnt_q;
        rd_vld_d      = rd_vld_q;
        victim_tag_d  = victim_tag_q;
        req_addr_d    = req_addr_q;
        req_ubhw_d    = req_ubhw_q;
        req_data_d    = req_data_q;
        req_ld_d      = req_ld_q;
        req_st_d      = req_st_q;
        data_r_d      = data_r_q;
        mem_cs_d      = mem_cs_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
`ifdef CACHE_STAT_EN
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
        first_d       = first_q;
`endif
        cache_addr    = '0;
        cache_load    = 1'b0;
        cache_edit    = 1'b0;
        cache_store   = 1'b0;
        cache_u_b_h_w = '0;
        cache_din     = '0;
        stall         = (en_r | en_w) & ~((state_q == S_CHECK) & cache_hit);

        case (state_q)
            S_IDLE: begin
                if (en_r | en_w) begin
                    cache_addr    = addr_rw;
                    cache_load    = en_r & ~en_w;
                    cache_edit    = en_w;
                    cache_din     = data_w;
                    cache_u_b_h_w = u_b_h_w;
                    req_addr_d    = addr_rw;
                    req_ubhw_d    = u_b_h_w;
                    req_data_d    = data_w;
                    req_ld_d      = en_r & ~en_w;
                    req_st_d      = en_w;
`ifdef CACHE_STAT_EN
                    first_d       = 1'b1;
`endif
                    state_d       = S_CHECK;
                end
            end
            S_CHECK: begin
                word_cnt_d = '0;
                rd_vld_d   = 1'b0;
                if (cache_hit) begin
                    if (req_ld_q) begin
                        data_r_d = cache_dout;
                    end
`ifdef CACHE_STAT_EN
                    if (first_q && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                        hit_cnt_d = hit_cnt_q + 32'd1;
                    end
`endif
                    state_d = S_IDLE;
                end else begin
                    victim_tag_d = cache_tag;
`ifdef CACHE_STAT_EN
                    if (first_q && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                        miss_cnt_d = miss_cnt_q + 32'd1;
                    end
`endif
                    state_d = (cache_valid & cache_dirty) ? S_BACK : S_FILL;
                end
            end
            S_BACK: begin
                // Victim word is read one cycle before it is offered to memory.
                cache_addr = line_addr;
                if (!rd_vld_q) begin
                    rd_vld_d = 1'b1;
                end else if (!mem_cs_q) begin
                    mem_cs_d   = 1'b1;
                    mem_we_d   = 1'b1;
                    mem_addr_d = victim_addr;
                    mem_din_d  = cache_dout;
                end else if (mem_ack) begin
                    mem_cs_d   = 1'b0;
                    mem_we_d   = 1'b0;
                    rd_vld_d   = 1'b0;
                    word_cnt_d = word_cnt_q + WC_BITS'(1);
                    if (word_cnt_q == WC_BITS'(LINE_WORDS - 1)) begin
                        state_d = S_FILL;
                    end
                end
            end
            S_FILL: begin
                if (!mem_cs_q) begin
                    mem_cs_d   = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = line_addr;
                end else if (mem_ack) begin
                    cache_store   = 1'b1;
                    cache_addr    = mem_addr_q;
                    cache_din     = mem_dout;
                    cache_u_b_h_w = UBHW_WORD;
                    mem_cs_d      = 1'b0;
                    word_cnt_d    = word_cnt_q + WC_BITS'(1);
                    if (word_cnt_q == WC_BITS'(LINE_WORDS - 1)) begin
                        state_d = S_RETRY;
                    end
                end
            end
            S_RETRY: begin
                cache_addr    = req_addr_q;
                cache_load    = req_ld_q;
                cache_edit    = req_st_q;
                cache_din     = req_data_q;
                cache_u_b_h_w = req_ubhw_q;
`ifdef CACHE_STAT_EN
                first_d       = 1'b0;
`endif
                state_d       = S_CHECK;
            end
            default: state_d = S_IDLE;
        endcase

        // Combinational outputs must read as zero while reset is held.
        if (!rst) begin
            cache_addr    = '0;
            cache_load    = 1'b0;
            cache_edit    = 1'b0;
            cache_store   = 1'b0;
            cache_u_b_h_w = '0;
            cache_din     = '0;
            stall         = 1'b0;
        end
    end

endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Cache management unit that sits between the CPU memory stage and the 2-way set-associative cache array.
- Turns CPU load/store requests into cache lookups.
- On a miss: writes back a dirty victim line (4 words), refills the line from main memory, then replays the access.
- Stalls the CPU while the access is outstanding.

Parameters:
- ADDR_BITS, 32, address width
- TAG_BITS, 23, tag width (addr[31:9])
- INDEX_BITS, 5, set index width (addr[8:4])
- LINE_WORDS, 4, words per line (word select addr[3:2])

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-low reset
- addr_rw  in  32  CPU byte address
- en_r  in  1  CPU load request
- en_w  in  1  CPU store request
- u_b_h_w  in  3  width/sign select, RV32I LB/LH/LW/LBU/LHU encoding
- data_w  in  32  CPU store data
- data_r  out  32  CPU load data
- stall  out  1  CPU stall
- cache_addr  out  32  address to cache array
- cache_load  out  1  cache read with recent-bit update
- cache_edit  out  1  cache write-on-hit
- cache_store  out  1  cache line-word fill
- cache_u_b_h_w  out  3  width to cache
- cache_din  out  32  data to cache
- cache_hit  in  1  registered hit
- cache_dout  in  32  registered read data or victim word
- cache_valid  in  1  registered victim valid
- cache_dirty  in  1  registered victim dirty
- cache_tag  in  23  registered victim tag
- mem_cs  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  32  memory word address
- mem_din  out  32  write data to memory
- mem_dout  in  32  read data from memory
- mem_ack  in  1  memory handshake complete

Behaviour:
- Reset (rst=0, async):
  - state=S_IDLE, word_cnt=0, rd_vld=0.
  - All outputs 0: data_r, stall, mem_cs, mem_we, mem_addr, mem_din, cache_addr and all cache controls.
  - Any in-flight request is dropped; the CPU re-presents it after reset.
- Cache outputs are registered, so cache array latency is 1 cycle. Every lookup is evaluated one cycle after issue.
- States: S_IDLE, S_CHECK, S_BACK, S_FILL, S_RETRY.
- S_IDLE:
  - On en_r|en_w: drive cache_addr=addr_rw, cache_load=en_r, cache_edit=en_w, cache_din=data_w, cache_u_b_h_w=u_b_h_w.
  - Then -> S_CHECK.
  - en_r and en_w both high: treated as a store (en_w wins).
- S_CHECK:
  - cache_hit=1: data_r<=cache_dout for loads, stall low this cycle, -> S_IDLE. Hit latency 2 cycles, 1 stall cycle.
  - Miss: capture victim_tag<=cache_tag.
  - Miss with cache_valid&cache_dirty -> S_BACK.
  - Miss otherwise -> S_FILL.
  - word_cnt cleared on exit in all cases.
- S_BACK (victim write-back):
  - cache_addr={addr tag, index, word_cnt, 2'b00}, cache_load=0. The victim word appears on cache_dout the next cycle; rd_vld marks it.
  - Once rd_vld=1: mem_cs=1, mem_we=1, mem_addr={victim_tag, index, word_cnt, 2'b00}, mem_din=cache_dout.
  - mem_cs, mem_we, mem_addr and mem_din are held stable until mem_ack.
  - On ack: word_cnt++, rd_vld=0, mem_cs low for at least 1 cycle.
  - After word 3 acked -> S_FILL, word_cnt=0.
- S_FILL (refill):
  - mem_cs=1, mem_we=0, mem_addr={addr tag, index, word_cnt, 2'b00}.
  - On mem_ack, same cycle: cache_store=1, cache_addr=mem_addr, cache_din=mem_dout, word_cnt++.
  - After word 3 -> S_RETRY.
  - Store targets the same way for all 4 words, because store does not update the recent bits.
- S_RETRY: reissue the original lookup exactly as in S_IDLE, then -> S_CHECK; the hit is guaranteed.
- stall = (en_r|en_w) & ~(state==S_CHECK & cache_hit).
- The request registers (addr, u_b_h_w, data_w, en_r/en_w) are latched in S_IDLE. CPU input changes during a stall are ignored.
- mem_ack while mem_cs=0 is ignored.
- word_cnt is 2 bits and wraps after 3; the wrap equals line completion.
- cache_invalid is tied 0. The port list carries no invalid output.

Optional Feature:
- Macro CACHE_STAT_EN.
- Defined: adds outputs hit_cnt[31:0] and miss_cnt[31:0].
  - Incremented in S_CHECK on the first lookup only; the S_RETRY lookup is not counted.
  - Both reset to 0 and saturate at 32'hFFFFFFFF.
- Undefined: no counters and no ports. Behaviour is otherwise identical.

Test Plan:
- Cold read: en_r, addr 0x0000_0104, cache empty, mem returns 0x11,0x22,0x33,0x44 for words 0-3, ack 1 cycle after each cs.
  -> mem_we never 1; 4 cache_store pulses; data_r=0x22; stall deasserts in S_CHECK after S_RETRY.
- Read hit: repeat the same address.
  -> zero mem_cs; stall high exactly 1 cycle; data_r=0x22.
- Store hit then dirty eviction:
  - SW 0xDEADBEEF to 0x104.
  - Load 0x0000_0304 (same index, way 2).
  - Load 0x0000_0504 (evicts LRU way 1).
  -> Write-back addresses 0x100, 0x104, 0x108, 0x10C; mem_din on 0x104 = 0xDEADBEEF; then 4 refills from 0x500.
- Byte/half loads: line with 0x8070_6050, LB at byte 3 -> 0xFFFF_FF80; LBU at byte 3 -> 0x0000_0080; LH at offset 2 -> 0xFFFF_8070.
- Slow memory: mem_ack delayed 5 cycles on each beat.
  -> mem_addr and mem_din stable across the wait; exactly 4 beats per phase.
- Reset mid-S_BACK after beat 2: rst low for 1 cycle.
  -> mem_cs=0 and stall=0 immediately (async); state S_IDLE.
  - With CACHE_STAT_EN defined: hit_cnt=0, miss_cnt=0.
